control_sequencer: RTL and testbench

//  Control unit for the BE8 8-bit CPU; the datapath is its counterpart.

---
 rtl/be8_pkg.sv | 51 +++++
 rtl/step_edge.sv | 21 ++
 rtl/control_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_control_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/be8_pkg.sv
// Shared encodings for the BE8 control unit: opcodes, sequencer states and the
// internal control-word bit order (every bit active-high inside the control unit).
package be8_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_IN  = 4'h9;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // T-states encode their own number so T_STATE can be taken straight from the register.
  typedef enum logic [2:0] {
    StT0   = 3'd0,
    StT1   = 3'd1,
    StT2   = 3'd2,
    StT3   = 3'd3,
    StT4   = 3'd4,
    StClr  = 3'd5,
    StHalt = 3'd6
  } state_e;

  localparam int unsigned CwW  = 18;
  localparam int unsigned CwCe = 17;
  localparam int unsigned CwSu = 16;
  localparam int unsigned CwRi = 15;
  localparam int unsigned CwAi = 14;
  localparam int unsigned CwBi = 13;
  localparam int unsigned CwOi = 12;
  localparam int unsigned CwIi = 11;
  localparam int unsigned CwJ  = 10;
  localparam int unsigned CwFi = 9;
  localparam int unsigned CwMi = 8;
  localparam int unsigned CwDo = 7;
  localparam int unsigned CwAo = 6;
  localparam int unsigned CwBo = 5;
  localparam int unsigned CwIo = 4;
  localparam int unsigned CwCo = 3;
  localparam int unsigned CwEo = 2;
  localparam int unsigned CwRo = 1;
  localparam int unsigned CwNo = 0;

  typedef logic [CwW-1:0] cw_t;

endpackage

// File: rtl/step_edge.sv
// Single-step edge detector: pulses step_rise_o on the first cycle STEP is seen high.
module step_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic step_i,
  output logic step_rise_o
);

  logic step_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step_i;
    end
  end

  assign step_rise_o = step_i & ~step_q;

endmodule

// File: rtl/control_sequencer.sv
// BE8 control unit: 5 T-state fetch/execute sequencer with free-run/single-step,
// post-reset CLR pulse and HALT state; decodes state/opcode/flags to datapath strobes.
module control_sequencer
  import be8_pkg::*;
#(
  parameter int unsigned ClrCycles = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       run_i,
  input  logic       step_i,
  input  logic [3:0] opcode_i,
  input  logic       cf_i,
  input  logic       zf_i,
  output logic       clr_o,
  output logic       ce_o,
  output logic       su_o,
  output logic       ri_o,
  output logic       ain_o,
  output logic       bin_o,
  output logic       oin_o,
  output logic       iin_o,
  output logic       jn_o,
  output logic       fin_o,
  output logic       min_o,
  output logic       don_o,
  output logic       aon_o,
  output logic       bon_o,
  output logic       ion_o,
  output logic       con_o,
  output logic       eon_o,
  output logic       ron_o,
  output logic       non_o,
  output logic [2:0] t_state_o,
  output logic       halted_o
);

  localparam int unsigned ClrW = (ClrCycles > 1) ? $clog2(ClrCycles) : 1;

  state_e          state_q, state_d;
  logic [ClrW-1:0] clr_cnt_q, clr_cnt_d;
  logic            step_rise;
  logic            adv;
  cw_t             cw, cw_gated;

  step_edge u_step_edge (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .step_i      (step_i),
    .step_rise_o (step_rise)
  );

  assign adv = run_i | step_rise;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StClr;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      StClr: begin
        if (clr_cnt_q == ClrW'(ClrCycles - 1)) begin
          state_d   = StT0;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      StT0: if (adv) state_d = StT1;
      StT1: if (adv) state_d = StT2;
      StT2: if (adv) state_d = (opcode_i == OP_HLT) ? StHalt : StT3;
      StT3: if (adv) state_d = StT4;
      StT4: if (adv) state_d = StT0;
      StHalt: state_d = StHalt;
      default: state_d = StClr;
    endcase
  end

  // Micro-op decode; flags only matter in T2, opcode ignored during fetch.
  always_comb begin
    cw = '0;
    unique case (state_q)
      StT0: begin
        cw[CwCo] = 1'b1;
        cw[CwMi] = 1'b1;
      end
      StT1: begin
        cw[CwRo] = 1'b1;
        cw[CwIi] = 1'b1;
        cw[CwCe] = 1'b1;
      end
      StT2: begin
        case (opcode_i)
          OP_NOP: ;
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            cw[CwIo] = 1'b1;
            cw[CwMi] = 1'b1;
          end
          OP_LDI: begin
            cw[CwIo] = 1'b1;
            cw[CwAi] = 1'b1;
          end
          OP_JMP: begin
            cw[CwIo] = 1'b1;
            cw[CwJ]  = 1'b1;
          end
          OP_JC: begin
            cw[CwIo] = cf_i;
            cw[CwJ]  = cf_i;
          end
          OP_JZ: begin
            cw[CwIo] = zf_i;
            cw[CwJ]  = zf_i;
          end
          OP_IN: begin
            cw[CwNo] = 1'b1;
            cw[CwAi] = 1'b1;
          end
          OP_OUT: begin
            cw[CwAo] = 1'b1;
            cw[CwOi] = 1'b1;
          end
          default: ;
        endcase
      end
      StT3: begin
        case (opcode_i)
          OP_LDA: begin
            cw[CwRo] = 1'b1;
            cw[CwAi] = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw[CwRo] = 1'b1;
            cw[CwBi] = 1'b1;
          end
          OP_STA: begin
            cw[CwAo] = 1'b1;
            cw[CwRi] = 1'b1;
          end
          default: ;
        endcase
      end
      StT4: begin
        if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
          cw[CwEo] = 1'b1;
          cw[CwAi] = 1'b1;
          cw[CwFi] = 1'b1;
          cw[CwSu] = (opcode_i == OP_SUB);
        end
      end
      default: cw = '0;
    endcase
  end

  // A paused CPU must load nothing, so strobes only fire on advancing cycles.
  assign cw_gated = adv ? cw : '0;

  assign clr_o    = (state_q == StClr);
  assign halted_o = (state_q == StHalt);

  always_comb begin
    t_state_o = state_q;
    if (state_q == StClr) t_state_o = 3'd0;
    if (state_q == StHalt) t_state_o = 3'd2;
  end

  assign ce_o  = cw_gated[CwCe];
  assign su_o  = cw_gated[CwSu];
  assign ri_o  = cw_gated[CwRi];
  assign ain_o = ~cw_gated[CwAi];
  assign bin_o = ~cw_gated[CwBi];
  assign oin_o = ~cw_gated[CwOi];
  assign iin_o = ~cw_gated[CwIi];
  assign jn_o  = ~cw_gated[CwJ];
  assign fin_o = ~cw_gated[CwFi];
  assign min_o = ~cw_gated[CwMi];
  assign don_o = ~cw_gated[CwDo];
  assign aon_o = ~cw_gated[CwAo];
  assign bon_o = ~cw_gated[CwBo];
  assign ion_o = ~cw_gated[CwIo];
  assign con_o = ~cw_gated[CwCo];
  assign eon_o = ~cw_gated[CwEo];
  assign ron_o = ~cw_gated[CwRo];
  assign non_o = ~cw_gated[CwNo];

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: expected output words are queued per step
// and popped against the DUT mid-cycle.
module tb_control_sequencer;

  // Active-high strobe masks in bench order: ce su ri ai bi oi ii j fi mi do ao bo io co eo ro no
  localparam logic [17:0] CE = 18'h20000;
  localparam logic [17:0] SU = 18'h10000;
  localparam logic [17:0] RI = 18'h08000;
  localparam logic [17:0] AI = 18'h04000;
  localparam logic [17:0] BI = 18'h02000;
  localparam logic [17:0] OI = 18'h01000;
  localparam logic [17:0] II = 18'h00800;
  localparam logic [17:0] JJ = 18'h00400;
  localparam logic [17:0] FI = 18'h00200;
  localparam logic [17:0] MI = 18'h00100;
  localparam logic [17:0] AO = 18'h00040;
  localparam logic [17:0] IO = 18'h00010;
  localparam logic [17:0] CO = 18'h00008;
  localparam logic [17:0] EO = 18'h00004;
  localparam logic [17:0] RO = 18'h00002;
  localparam logic [17:0] NO = 18'h00001;
  localparam logic [17:0] NONE = 18'h0;

  typedef struct {
    string       tag;
    logic [22:0] v;
  } exp_t;

  logic       clk, rst, run, step, cf, zf;
  logic [3:0] opcode;
  logic clr, ce, su, ri, ain, bin, oin, iin, jn, fin, min;
  logic don, aon, bon, ion, con, eon, ron, non, halted;
  logic [2:0] t_state;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  control_sequencer dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .run_i     (run),
    .step_i    (step),
    .opcode_i  (opcode),
    .cf_i      (cf),
    .zf_i      (zf),
    .clr_o     (clr),
    .ce_o      (ce),
    .su_o      (su),
    .ri_o      (ri),
    .ain_o     (ain),
    .bin_o     (bin),
    .oin_o     (oin),
    .iin_o     (iin),
    .jn_o      (jn),
    .fin_o     (fin),
    .min_o     (min),
    .don_o     (don),
    .aon_o     (aon),
    .bon_o     (bon),
    .ion_o     (ion),
    .con_o     (con),
    .eon_o     (eon),
    .ron_o     (ron),
    .non_o     (non),
    .t_state_o (t_state),
    .halted_o  (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [22:0] mk(input logic c, input logic h, input logic [2:0] t,
                                     input logic [17:0] act);
    return {c, h, t, act[17:15], ~act[14:0]};
  endfunction

  function automatic logic [22:0] observed();
    return {clr, halted, t_state, ce, su, ri, ain, bin, oin, iin, jn, fin, min,
            don, aon, bon, ion, con, eon, ron, non};
  endfunction

  task automatic expect_now(input string tag, input logic c, input logic h,
                            input logic [2:0] t, input logic [17:0] act);
    exp_t e;
    e.tag = tag;
    e.v   = mk(c, h, t, act);
    q.push_back(e);
  endtask

  task automatic compare_now();
    exp_t e;
    logic [22:0] obs;
    e   = q.pop_front();
    obs = observed();
    n_checks++;
    assert (obs === e.v) n_pass++;
    else $error("FAIL %s: observed %06h expected %06h (clr,halt,t,ce,su,ri,*n)", e.tag, obs, e.v);
  endtask

  // Check mid-cycle, then step to just after the next rising edge.
  task automatic chk(input string tag, input logic c, input logic h,
                     input logic [2:0] t, input logic [17:0] act);
    expect_now(tag, c, h, t, act);
    @(negedge clk);
    compare_now();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input string tag, input logic [3:0] op, input logic c, input logic z,
                       input logic [17:0] e2, input logic [17:0] e3, input logic [17:0] e4);
    opcode = op;
    cf     = c;
    zf     = z;
    chk({tag, "_T0"}, 1'b0, 1'b0, 3'd0, CO | MI);
    chk({tag, "_T1"}, 1'b0, 1'b0, 3'd1, RO | II | CE);
    chk({tag, "_T2"}, 1'b0, 1'b0, 3'd2, e2);
    chk({tag, "_T3"}, 1'b0, 1'b0, 3'd3, e3);
    chk({tag, "_T4"}, 1'b0, 1'b0, 3'd4, e4);
  endtask

  initial begin
    rst = 1'b1; run = 1'b1; step = 1'b0; opcode = 4'h0; cf = 1'b0; zf = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_hold", 1'b1, 1'b0, 3'd0, NONE);
    rst = 1'b0;
    chk("clr_cycle", 1'b1, 1'b0, 3'd0, NONE);

    instr("nop", 4'h0, 1'b0, 1'b0, NONE, NONE, NONE);
    instr("lda", 4'h1, 1'b0, 1'b0, IO | MI, RO | AI, NONE);
    instr("add", 4'h2, 1'b0, 1'b0, IO | MI, RO | BI, EO | AI | FI);
    instr("sub", 4'h3, 1'b0, 1'b0, IO | MI, RO | BI, EO | AI | FI | SU);
    instr("sta", 4'h4, 1'b0, 1'b0, IO | MI, AO | RI, NONE);
    instr("ldi", 4'h5, 1'b0, 1'b0, IO | AI, NONE, NONE);
    instr("jmp", 4'h6, 1'b0, 1'b0, IO | JJ, NONE, NONE);
    instr("jc0", 4'h7, 1'b0, 1'b1, NONE, NONE, NONE);
    instr("jc1", 4'h7, 1'b1, 1'b0, IO | JJ, NONE, NONE);
    instr("jz0", 4'h8, 1'b1, 1'b0, NONE, NONE, NONE);
    instr("jz1", 4'h8, 1'b0, 1'b1, IO | JJ, NONE, NONE);
    instr("in", 4'h9, 1'b0, 1'b0, NO | AI, NONE, NONE);
    instr("out", 4'hE, 1'b0, 1'b0, AO | OI, NONE, NONE);
    instr("opB", 4'hB, 1'b1, 1'b1, NONE, NONE, NONE);

    // HLT enters the terminal state after T2.
    opcode = 4'hF;
    chk("hlt_T0", 1'b0, 1'b0, 3'd0, CO | MI);
    chk("hlt_T1", 1'b0, 1'b0, 3'd1, RO | II | CE);
    chk("hlt_T2", 1'b0, 1'b0, 3'd2, NONE);
    for (int i = 0; i < 20; i++) begin
      run  = i[0];
      step = i[1];
      chk("halted", 1'b0, 1'b1, 3'd2, NONE);
    end
    run  = 1'b1;
    step = 1'b0;
    rst  = 1'b1;
    #1;
    expect_now("halt_reset_async", 1'b1, 1'b0, 3'd0, NONE);
    compare_now();
    @(posedge clk);
    #1;
    rst = 1'b0;
    opcode = 4'h0;
    chk("halt_clr", 1'b1, 1'b0, 3'd0, NONE);

    // Single-step: holding STEP advances exactly once.
    run = 1'b0;
    chk("pause_T0_a", 1'b0, 1'b0, 3'd0, NONE);
    chk("pause_T0_b", 1'b0, 1'b0, 3'd0, NONE);
    step = 1'b1;
    chk("step_T0", 1'b0, 1'b0, 3'd0, CO | MI);
    for (int i = 0; i < 9; i++) chk("step_hold", 1'b0, 1'b0, 3'd1, NONE);
    step = 1'b0;
    chk("step_low", 1'b0, 1'b0, 3'd1, NONE);
    step = 1'b1;
    chk("step_T1", 1'b0, 1'b0, 3'd1, RO | II | CE);
    step = 1'b0;
    chk("step_T2_wait", 1'b0, 1'b0, 3'd2, NONE);
    run = 1'b1;
    chk("resume_T2", 1'b0, 1'b0, 3'd2, NONE);
    chk("resume_T3", 1'b0, 1'b0, 3'd3, NONE);
    chk("resume_T4", 1'b0, 1'b0, 3'd4, NONE);

    // Reset in T3 of LDA aborts the instruction immediately.
    opcode = 4'h1;
    chk("lda2_T0", 1'b0, 1'b0, 3'd0, CO | MI);
    chk("lda2_T1", 1'b0, 1'b0, 3'd1, RO | II | CE);
    chk("lda2_T2", 1'b0, 1'b0, 3'd2, IO | MI);
    expect_now("lda2_T3_pre", 1'b0, 1'b0, 3'd3, RO | AI);
    compare_now();
    rst = 1'b1;
    #1;
    expect_now("lda2_T3_reset", 1'b1, 1'b0, 3'd0, NONE);
    compare_now();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("post_clr", 1'b1, 1'b0, 3'd0, NONE);
    chk("post_T0", 1'b0, 1'b0, 3'd0, CO | MI);
    chk("post_T1", 1'b0, 1'b0, 3'd1, RO | II | CE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
